nfca_tx_frombytes: RTL and testbench
====================================

Name: nfca_tx_frombytes

Overview:
Transmit-side byte serializer for the NFC-A (ISO14443A) PCD controller. It accepts a frame as a byte stream with a valid/ready handshake and a partial-last-byte bit count. It emits an ordered stream of symbols to the PCD modulator: start of communication (S), data bits LSB-first, odd parity per complete byte, and end of communication (E). It sits between the controller's TX byte interface and the Modified-Miller bit encoder.

Parameters:
FETCH_TIMEOUT, 16, max clk cycles to wait for the next byte of an unfinished frame before declaring underrun.

Ports:
clk  input  1  system clock, 81.36 MHz
rst  input  1  reset, synchronous, active-high
tx_tvalid  input  1  byte valid
tx_tready  output  1  byte accepted when tx_tvalid & tx_tready
tx_tdata  input  8  byte, bit0 sent first
tx_tdatab  input  4  valid bit count of the last byte; only used when tx_tlast=1; 1..8 used as-is; 0 or >8 treated as 8
tx_tlast  input  1  marks the last byte of the frame
sym_valid  output  1  symbol valid
sym_ready  input  1  modulator takes the symbol when sym_valid & sym_ready
sym_kind  output  2  symbol kind: SOC=0, DATA=1, PAR=2, EOC=3
sym_bit  output  1  bit value for DATA/PAR; 0 for SOC/EOC
busy  output  1  high from byte acceptance in IDLE until EOC is accepted
tx_underrun  output  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. tx_tready=0, sym_valid=0, sym_kind=0, sym_bit=0, busy=0, tx_underrun=0 on the next cycle. Byte register, bit counter and timeout counter are cleared.
- Reset mid-frame: abort immediately. No EOC is emitted. The modulator is reset by the same rst.
- States: IDLE, SOC, DATA, PAR, FETCH, EOC.
- IDLE: tx_tready=1.
  - On accept: latch byte into byte_r; last_r=tx_tlast; nbits_r = tx_tlast ? norm(tx_tdatab) : 8.
  - Go to SOC on the next cycle. Latency from accept to sym_valid is 1 cycle.
- SOC: sym_valid=1, kind=SOC. On handshake: cnt=0, go to DATA.
- DATA: sym_valid=1, kind=DATA, sym_bit=byte_r[cnt]. On handshake:
  - if cnt<nbits_r-1: cnt++.
  - else if nbits_r==8: go to PAR.
  - else: go to EOC. A partial last byte has no parity.
- PAR: sym_bit = ~^byte_r (odd parity: ones in byte plus parity bit is odd). On handshake: go to EOC if last_r, else go to FETCH.
- FETCH: sym_valid=0, tx_tready=1, timeout counter increments each cycle.
  - On accept: latch as in IDLE, cnt=0, go to DATA. No SOC is sent.
  - If the counter reaches FETCH_TIMEOUT without an accept: tx_underrun pulses, go to EOC. The frame is terminated cleanly.
- EOC: sym_valid=1, kind=EOC. On handshake: go to IDLE; busy drops on the following cycle.
- tx_tready is 0 in SOC/DATA/PAR/EOC. It is never high while sym_valid=1.
- Output stability: while sym_valid & ~sym_ready, sym_kind and sym_bit hold constant. At most one symbol advances per cycle.
- Single-byte frames with nbits<8 (e.g. REQA/WUPA short frame, anticollision split byte) produce SOC, nbits DATA symbols, then EOC.

Decomposition:
- Package nfca_pkg holds:
  - sym_kind enum (SOC/DATA/PAR/EOC) and its width constant.
  - Full-byte constant 4'd8.
  - A norm_datab function mapping 0/>8 to 8.
- No sub-module is needed; odd-parity is a one-line expression. The package is shared with the RX path and the modulator.

Test Plan:
1. Send 0x26, tlast=1, tdatab=7 (REQA). Required symbols: SOC, DATA 0,1,1,0,0,1,0, EOC. No PAR symbol; busy falls after EOC.
2. Send 0x93 then 0x20 (tlast=1, tdatab=8). Required: SOC, DATA 1,1,0,0,1,0,0,1, PAR 1, DATA 0,0,0,0,0,1,0,0, PAR 0, EOC.
3. Backpressure: hold sym_ready=0 for 5 cycles at every symbol during test 2. sym_kind and sym_bit stay constant; the symbol sequence is identical.
4. Send 0x50, tlast=1, tdatab=0. Required: 8 DATA bits 0,0,0,0,1,0,1,0, PAR 1, EOC.
5. Underrun: send 0x93 with tlast=0, then no tvalid. FETCH_TIMEOUT cycles after PAR is accepted, tx_underrun pulses once, then EOC follows and busy drops.
6. Assert rst for 1 cycle during DATA of byte 2. Next cycle all outputs are 0 and no EOC is emitted. A new REQA afterwards produces the test 1 sequence.

Source files
------------

// File: rtl/nfca_pkg.sv
// Shared NFC-A definitions: symbol kinds, byte constants and bit-count helpers.
package nfca_pkg;

   localparam int unsigned SYM_KIND_W = 2;

   typedef enum logic [SYM_KIND_W-1:0] {
      SymSoc  = 2'd0,
      SymData = 2'd1,
      SymPar  = 2'd2,
      SymEoc  = 2'd3
   } sym_kind_e;

   localparam logic [3:0] FULL_BYTE = 4'd8;

   // A last-byte bit count of 0 or above 8 means a full byte.
   function automatic logic [3:0] norm_datab(input logic [3:0] datab);
      return ((datab == 4'd0) || (datab > FULL_BYTE)) ? FULL_BYTE : datab;
   endfunction

endpackage

// File: rtl/nfca_tx_frombytes.sv
// NFC-A transmit serializer: byte stream in, SOC / LSB-first data / odd parity / EOC symbols out.
module nfca_tx_frombytes
   import nfca_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_tvalid,
   output logic                  tx_tready,
   input  logic [7:0]            tx_tdata,
   input  logic [3:0]            tx_tdatab,
   input  logic                  tx_tlast,
   output logic                  sym_valid,
   input  logic                  sym_ready,
   output logic [SYM_KIND_W-1:0] sym_kind,
   output logic                  sym_bit,
   output logic                  busy,
   output logic                  tx_underrun
);

   localparam int unsigned TMO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSoc,
      StData,
      StPar,
      StFetch,
      StEoc
   } state_e;

   state_e           r_state;
   state_e           w_state_d;
   // Holds tx_tready low for the first cycle after reset.
   logic             r_init;
   logic [7:0]       r_byte;
   logic             r_last;
   logic [3:0]       r_nbits;
   logic [3:0]       r_cnt;
   logic [TMO_W-1:0] r_tmo;

   logic             w_tready;
   logic             w_valid;
   sym_kind_e        w_kind;
   logic             w_bit;
   logic             w_load;
   logic             w_cnt_clr;
   logic             w_cnt_inc;
   logic             w_tmo_clr;
   logic             w_tmo_inc;
   logic             w_underrun;

   // Next-state, datapath controls and symbol outputs decoded from the current state.
   always_comb begin
      w_state_d  = r_state;
      w_tready   = 1'b0;
      w_valid    = 1'b0;
      w_kind     = SymSoc;
      w_bit      = 1'b0;
      w_load     = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
      w_tmo_clr  = 1'b0;
      w_tmo_inc  = 1'b0;
      w_underrun = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_tready = r_init;
            if (tx_tvalid && r_init) begin
               w_load    = 1'b1;
               w_state_d = StSoc;
            end
         end
         StSoc: begin
            w_valid = 1'b1;
            w_kind  = SymSoc;
            if (sym_ready) begin
               w_cnt_clr = 1'b1;
               w_state_d = StData;
            end
         end
         StData: begin
            w_valid = 1'b1;
            w_kind  = SymData;
            w_bit   = r_byte[r_cnt[2:0]];
            if (sym_ready) begin
               if (r_cnt < (r_nbits - 4'd1)) begin
                  w_cnt_inc = 1'b1;
               end else if (r_nbits == FULL_BYTE) begin
                  w_state_d = StPar;
               end else begin
                  // Partial last byte carries no parity.
                  w_state_d = StEoc;
               end
            end
         end
         StPar: begin
            w_valid = 1'b1;
            w_kind  = SymPar;
            w_bit   = ~^r_byte;
            if (sym_ready) begin
               if (r_last) begin
                  w_state_d = StEoc;
               end else begin
                  w_tmo_clr = 1'b1;
                  w_state_d = StFetch;
               end
            end
         end
         StFetch: begin
            w_tready = r_init;
            if (tx_tvalid && r_init) begin
               w_load    = 1'b1;
               w_cnt_clr = 1'b1;
               w_state_d = StData;
            end else if (r_tmo == TMO_LAST) begin
               // Close the frame cleanly rather than leave the field modulated.
               w_underrun = 1'b1;
               w_state_d  = StEoc;
            end else begin
               w_tmo_inc = 1'b1;
            end
         end
         StEoc: begin
            w_valid = 1'b1;
            w_kind  = SymEoc;
            if (sym_ready) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous reset; mid-frame reset aborts without EOC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_init  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_init  <= 1'b1;
      end
   end

   // Byte, bit-count and timeout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte  <= 8'd0;
         r_last  <= 1'b0;
         r_nbits <= 4'd0;
         r_cnt   <= 4'd0;
         r_tmo   <= '0;
      end else begin
         if (w_load) begin
            r_byte  <= tx_tdata;
            r_last  <= tx_tlast;
            r_nbits <= tx_tlast ? norm_datab(tx_tdatab) : FULL_BYTE;
         end
         if (w_cnt_clr) begin
            r_cnt <= 4'd0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (w_tmo_clr) begin
            r_tmo <= '0;
         end else if (w_tmo_inc) begin
            r_tmo <= r_tmo + 1'b1;
         end
      end
   end

   assign tx_tready   = w_tready;
   assign sym_valid   = w_valid;
   assign sym_kind    = w_kind;
   assign sym_bit     = w_bit;
   assign busy        = (r_state != StIdle);
   assign tx_underrun = w_underrun;

endmodule

// File: tb/tb_nfca_tx_frombytes.sv
// Scoreboard bench for nfca_tx_frombytes: directed frames, backpressure, underrun, reset abort.
module tb_nfca_tx_frombytes;
   import nfca_pkg::*;

   localparam int unsigned FETCH_TIMEOUT = 16;

   logic                  clk;
   logic                  rst;
   logic                  tx_tvalid;
   logic                  tx_tready;
   logic [7:0]            tx_tdata;
   logic [3:0]            tx_tdatab;
   logic                  tx_tlast;
   logic                  sym_valid;
   logic                  sym_ready;
   logic [SYM_KIND_W-1:0] sym_kind;
   logic                  sym_bit;
   logic                  busy;
   logic                  tx_underrun;

   logic       bp_ready;
   logic       hold_ready;
   logic       bp_mode;
   int         n_tests;
   int         n_fail;
   int         n_under;
   int         cyc;
   int         last_par_cyc;
   logic [2:0] exp_q[$];

   assign sym_ready = bp_ready & ~hold_ready;

   nfca_tx_frombytes #(
      .FETCH_TIMEOUT(FETCH_TIMEOUT)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_tvalid  (tx_tvalid),
      .tx_tready  (tx_tready),
      .tx_tdata   (tx_tdata),
      .tx_tdatab  (tx_tdatab),
      .tx_tlast   (tx_tlast),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .sym_kind   (sym_kind),
      .sym_bit    (sym_bit),
      .busy       (busy),
      .tx_underrun(tx_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // S=SOC, 0/1=DATA bit, p/P=parity 0/1, E=EOC; each entry is {kind, bit}.
   function automatic void push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "S": exp_q.push_back({2'd0, 1'b0});
            "0": exp_q.push_back({2'd1, 1'b0});
            "1": exp_q.push_back({2'd1, 1'b1});
            "p": exp_q.push_back({2'd2, 1'b0});
            "P": exp_q.push_back({2'd2, 1'b1});
            "E": exp_q.push_back({2'd3, 1'b0});
            default: ;
         endcase
      end
   endfunction

   task automatic send_byte(input logic [7:0] data, input logic last, input logic [3:0] datab);
      bit acc;
      acc       = 1'b0;
      tx_tvalid = 1'b1;
      tx_tdata  = data;
      tx_tlast  = last;
      tx_tdatab = datab;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tx_tready) acc = 1'b1;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      tx_tvalid = 1'b0;
      tx_tdata  = 8'h00;
      tx_tlast  = 1'b0;
      tx_tdatab = 4'd0;
   endtask

   // Waits until every expected symbol has been taken; returns at posedge+1.
   task automatic wait_done(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_busy_low"}, 32'(busy), 32'd0);
      check({name, "_idle_ready"}, 32'(tx_tready), 32'd1);
   endtask

   // Backpressure generator: in bp_mode every symbol is stalled 5 cycles.
   initial begin
      int stall;
      bp_ready = 1'b1;
      stall    = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!bp_mode) begin
            bp_ready = 1'b1;
            stall    = 0;
         end else if (!sym_valid) begin
            bp_ready = 1'b0;
            stall    = 0;
         end else if (stall < 5) begin
            bp_ready = 1'b0;
            stall++;
         end else begin
            bp_ready = 1'b1;
            stall    = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every symbol handshake and checks stall stability.
   initial begin
      logic       prev_stall;
      logic [2:0] prev_sym;
      logic [2:0] e;
      int         n_sym;
      prev_stall = 1'b0;
      prev_sym   = 3'd0;
      n_sym      = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (prev_stall) begin
               check("stall_valid_held", 32'(sym_valid), 32'd1);
               check("stall_sym_stable", 32'({sym_kind, sym_bit}), 32'(prev_sym));
            end
            if (sym_valid) check("no_ready_while_valid", 32'(tx_tready), 32'd0);
            if (sym_valid && sym_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_sym", 32'({sym_kind, sym_bit}), 32'h7f);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("sym%0d", n_sym), 32'({sym_kind, sym_bit}), 32'(e));
               end
               n_sym++;
               if (sym_kind == 2'd2) last_par_cyc = cyc;
            end
            if (tx_underrun === 1'b1) begin
               n_under++;
               check("underrun_delay", 32'(cyc - last_par_cyc), FETCH_TIMEOUT);
            end
         end
         prev_stall = sym_valid && !sym_ready && !rst;
         prev_sym   = {sym_kind, sym_bit};
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      n_tests      = 0;
      n_fail       = 0;
      n_under      = 0;
      cyc          = 0;
      last_par_cyc = 0;
      bp_mode      = 1'b0;
      hold_ready   = 1'b0;
      rst          = 1'b1;
      tx_tvalid    = 1'b0;
      tx_tdata     = 8'h00;
      tx_tdatab    = 4'd0;
      tx_tlast     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_tready", 32'(tx_tready), 32'd0);
      check("rst_valid", 32'(sym_valid), 32'd0);
      check("rst_kind", 32'(sym_kind), 32'd0);
      check("rst_bit", 32'(sym_bit), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(tx_underrun), 32'd0);
      @(posedge clk);
      #1;
      check("idle_tready", 32'(tx_tready), 32'd1);

      // REQA short frame: 7 bits, no parity.
      push_str("S0110010E");
      send_byte(8'h26, 1'b1, 4'd7);
      check("t1_busy_high", 32'(busy), 32'd1);
      wait_done("t1");

      // Two full bytes with parity.
      push_str("S11001001P00000100pE");
      send_byte(8'h93, 1'b0, 4'd0);
      send_byte(8'h20, 1'b1, 4'd8);
      wait_done("t2");

      // Same frame under heavy backpressure.
      bp_mode = 1'b1;
      push_str("S11001001P00000100pE");
      send_byte(8'h93, 1'b0, 4'd0);
      send_byte(8'h20, 1'b1, 4'd8);
      wait_done("t3");
      bp_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // tdatab=0 on the last byte means a full byte.
      push_str("S00001010PE");
      send_byte(8'h50, 1'b1, 4'd0);
      wait_done("t4");

      // Underrun: no second byte follows.
      push_str("S11001001PE");
      send_byte(8'h93, 1'b0, 4'd0);
      wait_done("t5");
      check("t5_underrun_count", 32'(n_under), 32'd1);

      // Reset during the fourth data bit of byte 2.
      push_str("S11001001P000");
      send_byte(8'h93, 1'b0, 4'd0);
      send_byte(8'h20, 1'b1, 4'd8);
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (exp_q.size() == 0) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("t6_reach_byte2", 32'(found), 32'd1);
      hold_ready = 1'b1;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t6_tready", 32'(tx_tready), 32'd0);
      check("t6_valid", 32'(sym_valid), 32'd0);
      check("t6_kind", 32'(sym_kind), 32'd0);
      check("t6_bit", 32'(sym_bit), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_underrun", 32'(tx_underrun), 32'd0);
      hold_ready = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("t6_quiet", 32'(sym_valid), 32'd0);
      push_str("S0110010E");
      send_byte(8'h26, 1'b1, 4'd7);
      wait_done("t6_reqa");

      repeat (5) @(posedge clk);
      #1;
      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      check("total_underruns", 32'(n_under), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
